result_drain_writer: RTL and testbench
======================================

# result_drain_writer

Downstream stage of the 4x4 systolic array subsystem. On each `save_into_memory` strobe it snapshots the sixteen 16-bit results `r_00`..`r_33` and the accompanying `base_addr`, then drains them one word per accepted beat into the result memory over a valid/ready write port. This frees the array to start the next tile while the previous tile is written back.

## Interface
- `DATA_W`, 16, result word width (signed)
- `ADDR_W`, 8, result-memory address width
- `N`, 4, array dimension; NUM_ELEM = N*N = 16
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `save_into_memory`  in  1  capture strobe from the array wrapper
- `base_addr`  in  ADDR_W  tile base address, sampled with the strobe
- `r_00`..`r_33`  in  16 x DATA_W  array results, row-major, sampled with the strobe
- `wr_ready`  in  1  result memory accepts the current beat
- `wr_valid`  out  1  write beat present
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  DATA_W  write data
- `busy`  out  1  high in DRAIN and DONE
- `drain_done`  out  1  one-cycle pulse after the 16th beat is accepted
- `overflow`  out  1  sticky: a strobe was dropped

## Operation
- States: IDLE, DRAIN, DONE.
- IDLE: `save_into_memory`=1 -> latch all 16 results and `base_addr`, clear index, -> DRAIN.
- DRAIN: `wr_valid`=1; element idx = 4*row+col; `wr_addr` = base + idx, modulo 2^ADDR_W (wraps, no error); `wr_data` = latched element idx.
- Beat accepted when `wr_valid && wr_ready`; idx increments. Acceptance of idx 15 -> DONE.
- DONE (one cycle): `drain_done`=1. If `save_into_memory`=1 in this cycle, capture as in IDLE and -> DRAIN (back-to-back tiles); otherwise -> IDLE.
- Strobe while in DRAIN: ignored, snapshot untouched, `overflow` set; stays set until reset.
- `wr_ready` high while not in DRAIN: no effect.
- Results are stored and written verbatim (no width change) unless the configuration feature is compiled in.

## Timing
- Reset: state IDLE, idx 0, `wr_valid`/`busy`/`drain_done`/`overflow` = 0, `wr_addr`/`wr_data` = 0, snapshot registers 0.
- All outputs registered or decoded from registered state only; no combinational path from `wr_ready` to any output.
- Strobe sampled at edge N -> `wr_valid` high from N+1.
- With `wr_ready` held high: beats idx 0..15 in cycles N+1..N+16; `drain_done` at N+17; back-to-back strobe at N+17 gives next `wr_valid` at N+18.
- Stall: while `wr_valid && !wr_ready`, `wr_addr` and `wr_data` hold stable; drain length = 16 + number of stalled cycles.
- Reset asserted mid-drain: immediate abort, `wr_valid` falls asynchronously, remaining beats lost, no `drain_done`.

## Configuration
- `DRAIN_RELU_EN` defined: each element is passed through ReLU at capture (negative -> 0, non-negative unchanged); latency unchanged.
- Undefined: data written exactly as captured, negative values included.

## Structure
- Shared package `drain_pkg`: state enum (IDLE, DRAIN, DONE), `NUM_ELEM`=16, index width 4, default widths.
- One sub-module, `result_capture_bank`: 16 x DATA_W snapshot registers with load enable and 4-bit read mux (ReLU applied here when enabled).
- Top holds FSM, index counter, address adder, overflow flag.

## Test plan
- Reset, strobe with r_ij = 16*i+j, base 0x10, `wr_ready`=1 -> 16 beats addr 0x10..0x1F, data 0..0x33 row-major, `drain_done` at N+17.
- Same tile, `wr_ready` toggling 1/0 every cycle -> data/addr held during stalls, 16 accepted beats, `drain_done` after 31 cycles.
- base 0xFA -> addresses 0xFA..0xFF then 0x00..0x09, no `overflow`.
- Strobe at beat 5 of a drain -> ignored, original data continues, `overflow`=1 and stays 1; second strobe in DONE cycle -> new tile drains from N+18.
- r_00 = -5 (0xFFFB): with `DRAIN_RELU_EN` first beat data 0; without, 0xFFFB.
- Assert `rst` low at beat 7 -> `wr_valid` 0 immediately, all outputs 0, no `drain_done`; new strobe after release drains normally.

Source files
------------

// File: rtl/drain_pkg.sv
// drain_pkg
// Shared definitions for the systolic-array result drain path.
// Contents:
//   NUM_ELEM      number of result words per tile (4x4 array)
//   IDX_W         width of the element index used to walk a tile
//   DEF_DATA_W    default result word width
//   DEF_ADDR_W    default result-memory address width
//   drain_state_e writer FSM states (IDLE, DRAIN, DONE)
// Optional build macro used by the modules importing this package:
// DRAIN_RELU_EN.
package drain_pkg;

  localparam int NUM_ELEM   = 16;
  localparam int IDX_W      = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/result_capture_bank.sv
// result_capture_bank
// Snapshot storage for one 4x4 tile of results plus a read mux that
// selects one word by element index.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears every snapshot word)
//   load       capture load_data into the snapshot this cycle
//   load_data  16 packed result words, element 0 in the low slot
//   rd_idx     element index to present on rd_data
//   rd_data    snapshot word at rd_idx
// Build option: with DRAIN_RELU_EN defined, negative words are stored as
// zero at capture time so the drain itself is unaffected.
module result_capture_bank
  import drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [NUM_ELEM-1:0][DATA_W-1:0]  load_data,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [DATA_W-1:0]                rd_data
);

  logic [NUM_ELEM-1:0][DATA_W-1:0] snap;
  logic [NUM_ELEM-1:0][DATA_W-1:0] snap_d;

  // Word conditioning happens on the way in, keeping the read mux
  // a plain selector with no extra logic depth.
  always_comb begin
    snap_d = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
`ifdef DRAIN_RELU_EN
      snap_d[i] = load_data[i][DATA_W-1] ? '0 : load_data[i];
`else
      snap_d[i] = load_data[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
    end else if (load) begin
      snap <= snap_d;
    end
  end

  assign rd_data = snap[rd_idx];

endmodule

// File: rtl/result_drain_writer.sv
// result_drain_writer
// Captures a 4x4 tile of results and its base address on save_into_memory,
// then writes the tile one word per accepted beat to the result memory
// over a valid/ready port, freeing the array for the next tile.
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   save_into_memory  capture strobe from the array wrapper
//   base_addr         tile base address, sampled with the strobe
//   r_00..r_33        array results (row-major), sampled with the strobe
//   wr_ready          memory accepts the current beat
//   wr_valid          write beat present
//   wr_addr           base + element index, wrapping modulo 2^ADDR_W
//   wr_data           captured element at the current index
//   busy              high while draining or signalling completion
//   drain_done        one-cycle pulse after the last beat is accepted
//   overflow          sticky flag: a strobe arrived mid-drain and was dropped
// Build option: DRAIN_RELU_EN clamps negative results to zero at capture.
module result_drain_writer
  import drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_into_memory,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] r_00, r_01, r_02, r_03,
  input  logic [DATA_W-1:0] r_10, r_11, r_12, r_13,
  input  logic [DATA_W-1:0] r_20, r_21, r_22, r_23,
  input  logic [DATA_W-1:0] r_30, r_31, r_32, r_33,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              drain_done,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

  drain_state_e                    state;
  logic [IDX_W-1:0]                idx;
  logic [ADDR_W-1:0]               base_q;
  logic [NUM_ELEM-1:0][DATA_W-1:0] r_bus;
  logic                            capture;

  // Row-major packing: element 4*row+col lands in slot 4*row+col.
  assign r_bus = {r_33, r_32, r_31, r_30,
                  r_23, r_22, r_21, r_20,
                  r_13, r_12, r_11, r_10,
                  r_03, r_02, r_01, r_00};

  // A strobe is only honoured outside DRAIN, so a tile in flight is never
  // overwritten; the DONE cycle accepts it to allow back-to-back tiles.
  assign capture = save_into_memory && (state != DRAIN);

  result_capture_bank #(
    .DATA_W (DATA_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (r_bus),
    .rd_idx    (idx),
    .rd_data   (wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      base_q   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (save_into_memory) begin
            state  <= DRAIN;
            idx    <= '0;
            base_q <= base_addr;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (save_into_memory) begin
            overflow <= 1'b1;
          end
          if (wr_ready) begin
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; wr_ready never reaches them
  // combinationally.
  assign wr_valid   = (state == DRAIN);
  assign busy       = (state != IDLE);
  assign drain_done = (state == DONE);
  assign wr_addr    = base_q + ADDR_W'(idx);

endmodule

// File: tb/tb_result_drain_writer.sv
// tb_result_drain_writer
// Self-checking bench for result_drain_writer. Expected beats are derived
// from the captured tile: address = (base + i) mod 256, data = element i
// (clamped at zero when DRAIN_RELU_EN is defined). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_result_drain_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        save_into_memory = 1'b0;
  logic        wr_ready = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [15:0] r_arr [16];
  logic        wr_valid, busy, drain_done, overflow;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_val [16];
  logic [7:0]  exp_base;
  logic [7:0]  got_addr [16];
  logic [15:0] got_data [16];
  int          got_beats, last_acc, done_cyc, stall_cnt;
  bit          stable_ok;

  always #5 clk = ~clk;

  result_drain_writer #(.DATA_W(16), .ADDR_W(8), .N(4)) dut (
    .clk(clk), .rst(rst), .save_into_memory(save_into_memory), .base_addr(base_addr),
    .r_00(r_arr[0]),  .r_01(r_arr[1]),  .r_02(r_arr[2]),  .r_03(r_arr[3]),
    .r_10(r_arr[4]),  .r_11(r_arr[5]),  .r_12(r_arr[6]),  .r_13(r_arr[7]),
    .r_20(r_arr[8]),  .r_21(r_arr[9]),  .r_22(r_arr[10]), .r_23(r_arr[11]),
    .r_30(r_arr[12]), .r_31(r_arr[13]), .r_32(r_arr[14]), .r_33(r_arr[15]),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .drain_done(drain_done), .overflow(overflow)
  );

  function automatic logic [15:0] model_word(input logic [15:0] v);
`ifdef DRAIN_RELU_EN
    return ($signed(v) < 0) ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] model_addr(input logic [7:0] b, input int i);
    return 8'((int'(b) + i) % 256);
  endfunction

  task automatic randomize_tile();
    for (int i = 0; i < 16; i++) r_arr[i] = 16'($urandom);
    base_addr = 8'($urandom);
  endtask

  // Strobe the current r_arr/base_addr into the DUT and remember them as
  // the expected tile. Returns in cycle 1 of the drain.
  task automatic start_tile();
    for (int i = 0; i < 16; i++) exp_val[i] = r_arr[i];
    exp_base = base_addr;
    save_into_memory = 1'b1;
    @(posedge clk); #1;
    save_into_memory = 1'b0;
  endtask

  // Drive wr_ready (mode 0 always, 1 toggling from 1, 2 random) and record
  // accepted beats until drain_done, stop_beat beats, or limit cycles.
  task automatic collect(input int mode, input int strobe_beat, input int stop_beat, input int limit);
    logic [7:0]  prev_a;
    logic [15:0] prev_d;
    bit          prev_stall;
    got_beats = 0; last_acc = 0; done_cyc = -1; stall_cnt = 0; stable_ok = 1'b1;
    prev_stall = 1'b0; prev_a = '0; prev_d = '0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (drain_done) begin
        done_cyc = cyc;
        break;
      end
      if (stop_beat >= 0 && got_beats == stop_beat) break;
      if (prev_stall && (wr_addr !== prev_a || wr_data !== prev_d)) stable_ok = 1'b0;
      case (mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = (cyc % 2 == 1);
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
      if (strobe_beat >= 0 && got_beats == strobe_beat && wr_valid) save_into_memory = 1'b1;
      if (wr_valid && wr_ready) begin
        if (got_beats < 16) begin
          got_addr[got_beats] = wr_addr;
          got_data[got_beats] = wr_data;
        end
        got_beats++;
        last_acc = cyc;
        prev_stall = 1'b0;
      end else if (wr_valid) begin
        stall_cnt++;
        prev_stall = 1'b1;
        prev_a = wr_addr;
        prev_d = wr_data;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk); #1;
      save_into_memory = 1'b0;
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", wr_valid); end
    checks++; if ({busy, drain_done, overflow} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", {busy, drain_done, overflow}); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr got %h exp 00", wr_addr); end
    checks++; if (wr_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data got %h exp 0000", wr_data); end
    checks++; if ({wr_valid, busy, drain_done, overflow} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_after_release got %b exp 0000", {wr_valid, busy, drain_done, overflow}); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) r_arr[i] = 16'(16 * (i / 4) + (i % 4));
    base_addr = 8'h10;
    start_tile();
    checks++; if ({wr_valid, busy} !== 2'b11) begin errors++; $display("[TB] FAIL basic_first_cycle got %b exp 11", {wr_valid, busy}); end
    collect(0, -1, -1, 100);
    checks++; if (got_beats !== 16) begin errors++; $display("[TB] FAIL basic_beats got %0d exp 16", got_beats); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_addr[i] !== model_addr(8'h10, i)) begin errors++; $display("[TB] FAIL basic_addr[%0d] got %h exp %h", i, got_addr[i], model_addr(8'h10, i)); end
      checks++; if (got_data[i] !== model_word(16'(16 * (i / 4) + (i % 4)))) begin errors++; $display("[TB] FAIL basic_data[%0d] got %h exp %h", i, got_data[i], model_word(16'(16 * (i / 4) + (i % 4)))); end
    end
    checks++; if (done_cyc !== 17) begin errors++; $display("[TB] FAIL basic_done_cycle got %0d exp 17", done_cyc); end
    @(posedge clk); #1;
    checks++; if ({wr_valid, busy, drain_done, overflow} !== 4'b0000) begin errors++; $display("[TB] FAIL basic_idle got %b exp 0000", {wr_valid, busy, drain_done, overflow}); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) r_arr[i] = 16'(16 * (i / 4) + (i % 4));
    base_addr = 8'h10;
    start_tile();
    collect(1, -1, -1, 100);
    checks++; if (got_beats !== 16) begin errors++; $display("[TB] FAIL stall_beats got %0d exp 16", got_beats); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_addr[i] !== model_addr(exp_base, i) || got_data[i] !== model_word(exp_val[i])) begin
        errors++; $display("[TB] FAIL stall_beat[%0d] got %h/%h exp %h/%h", i, got_addr[i], got_data[i], model_addr(exp_base, i), model_word(exp_val[i]));
      end
    end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold got changed exp stable"); end
    checks++; if (stall_cnt !== 15) begin errors++; $display("[TB] FAIL stall_count got %0d exp 15", stall_cnt); end
    checks++; if (done_cyc !== 32) begin errors++; $display("[TB] FAIL stall_done_cycle got %0d exp 32", done_cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    randomize_tile();
    base_addr = 8'hFA;
    start_tile();
    collect(0, -1, -1, 100);
    checks++; if (got_beats !== 16) begin errors++; $display("[TB] FAIL wrap_beats got %0d exp 16", got_beats); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_addr[i] !== model_addr(8'hFA, i)) begin errors++; $display("[TB] FAIL wrap_addr[%0d] got %h exp %h", i, got_addr[i], model_addr(8'hFA, i)); end
      checks++; if (got_data[i] !== model_word(exp_val[i])) begin errors++; $display("[TB] FAIL wrap_data[%0d] got %h exp %h", i, got_data[i], model_word(exp_val[i])); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrap_overflow got %b exp 0", overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow_back_to_back();
    randomize_tile();
    start_tile();
    randomize_tile();
    collect(0, 5, -1, 100);
    checks++; if (got_beats !== 16) begin errors++; $display("[TB] FAIL ovf_beats got %0d exp 16", got_beats); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_addr[i] !== model_addr(exp_base, i) || got_data[i] !== model_word(exp_val[i])) begin
        errors++; $display("[TB] FAIL ovf_beat[%0d] got %h/%h exp %h/%h", i, got_addr[i], got_data[i], model_addr(exp_base, i), model_word(exp_val[i]));
      end
    end
    checks++; if (done_cyc !== 17) begin errors++; $display("[TB] FAIL ovf_done_cycle got %0d exp 17", done_cyc); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b exp 1", overflow); end
    // Strobe in the DONE cycle: next tile must start with no idle gap.
    randomize_tile();
    start_tile();
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_valid got %b exp 1", wr_valid); end
    collect(2, -1, -1, 300);
    checks++; if (got_beats !== 16) begin errors++; $display("[TB] FAIL b2b_beats got %0d exp 16", got_beats); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_addr[i] !== model_addr(exp_base, i) || got_data[i] !== model_word(exp_val[i])) begin
        errors++; $display("[TB] FAIL b2b_beat[%0d] got %h/%h exp %h/%h", i, got_addr[i], got_data[i], model_addr(exp_base, i), model_word(exp_val[i]));
      end
    end
    checks++; if (last_acc !== 16 + stall_cnt) begin errors++; $display("[TB] FAIL b2b_length got %0d exp %0d", last_acc, 16 + stall_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL b2b_overflow_sticky got %b exp 1", overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_negative();
    logic [15:0] first_exp;
`ifdef DRAIN_RELU_EN
    first_exp = 16'h0000;
`else
    first_exp = 16'hFFFB;
`endif
    randomize_tile();
    r_arr[0] = 16'hFFFB;
    r_arr[9] = 16'h8000;
    r_arr[15] = 16'h7FFF;
    start_tile();
    collect(0, -1, -1, 100);
    checks++; if (got_data[0] !== first_exp) begin errors++; $display("[TB] FAIL neg_first_data got %h exp %h", got_data[0], first_exp); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (got_data[i] !== model_word(exp_val[i])) begin errors++; $display("[TB] FAIL neg_data[%0d] got %h exp %h", i, got_data[i], model_word(exp_val[i])); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      randomize_tile();
      start_tile();
      collect(2, -1, -1, 300);
      checks++; if (got_beats !== 16) begin errors++; $display("[TB] FAIL rand%0d_beats got %0d exp 16", t, got_beats); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (got_addr[i] !== model_addr(exp_base, i) || got_data[i] !== model_word(exp_val[i])) begin
          errors++; $display("[TB] FAIL rand%0d_beat[%0d] got %h/%h exp %h/%h", t, i, got_addr[i], got_data[i], model_addr(exp_base, i), model_word(exp_val[i]));
        end
      end
      checks++; if (stable_ok !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_hold got changed exp stable", t); end
      checks++; if (done_cyc !== last_acc + 1 || last_acc !== 16 + stall_cnt) begin
        errors++; $display("[TB] FAIL rand%0d_timing got done %0d last %0d exp done %0d last %0d", t, done_cyc, last_acc, 17 + stall_cnt, 16 + stall_cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    bit done_seen;
    randomize_tile();
    start_tile();
    collect(0, -1, 7, 100);
    checks++; if (got_beats !== 7 || wr_addr !== model_addr(exp_base, 7)) begin
      errors++; $display("[TB] FAIL mid_pre_reset got beats %0d addr %h exp 7 %h", got_beats, wr_addr, model_addr(exp_base, 7));
    end
    rst = 1'b0;
    #1;
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid_drop got %b exp 0", wr_valid); end
    checks++; if ({busy, drain_done, overflow} !== 3'b000 || wr_addr !== 8'h00 || wr_data !== 16'h0000) begin
      errors++; $display("[TB] FAIL mid_outputs got %b %h %h exp 000 00 0000", {busy, drain_done, overflow}, wr_addr, wr_data);
    end
    done_seen = 1'b0;
    wr_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (drain_done) done_seen = 1'b1;
    end
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (drain_done || wr_valid) done_seen = 1'b1;
    end
    wr_ready = 1'b0;
    checks++; if (done_seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_done got activity exp none"); end
    randomize_tile();
    start_tile();
    collect(0, -1, -1, 100);
    checks++; if (got_beats !== 16 || done_cyc !== 17) begin errors++; $display("[TB] FAIL mid_restart got beats %0d done %0d exp 16 17", got_beats, done_cyc); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_addr[i] !== model_addr(exp_base, i) || got_data[i] !== model_word(exp_val[i])) begin
        errors++; $display("[TB] FAIL mid_restart_beat[%0d] got %h/%h exp %h/%h", i, got_addr[i], got_data[i], model_addr(exp_base, i), model_word(exp_val[i]));
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow_cleared got %b exp 0", overflow); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) r_arr[i] = 16'h0000;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_overflow_back_to_back();
    test_negative();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
